sa_input_feeder: RTL and testbench

//   Responder for the activation-read interface driven by the systolic controller (r_input_en/r_input_addr).

---
 rtl/sa_input_feeder_if.sv | 41 ++++
 rtl/sa_input_feeder.sv | 152 +++++++++++++++
 tb/tb_sa_input_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_input_feeder_if.sv
// Activation feeder bus: host write port, controller read port and the
// skewed activation outputs toward the array's west edge.
//   master : host/controller side (drives i_*, observes o_*)
//   slave  : the feeder (observes i_*, drives o_*)
// Signals:
//   i_wr_en / i_wr_addr / i_wr_data  host vector write
//   i_clear                          invalidate all stored entries
//   i_rd_en / i_rd_addr              controller read request
//   i_clear_err                      clear sticky error
//   o_act / o_act_valid              skewed activations, per-lane valid
//   o_busy                           read in flight or skew pipe non-empty
//   o_err                            sticky access error
interface sa_input_feeder_if #(
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                           i_wr_en;
    logic [ADDR_WIDTH-1:0]          i_wr_addr;
    logic [NUM_ROWS*DATA_WIDTH-1:0] i_wr_data;
    logic                           i_clear;
    logic                           i_rd_en;
    logic [ADDR_WIDTH-1:0]          i_rd_addr;
    logic                           i_clear_err;
    logic [NUM_ROWS*DATA_WIDTH-1:0] o_act;
    logic [NUM_ROWS-1:0]            o_act_valid;
    logic                           o_busy;
    logic                           o_err;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_clear,
        output i_rd_en, i_rd_addr, i_clear_err,
        input  o_act, o_act_valid, o_busy, o_err
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_clear,
        input  i_rd_en, i_rd_addr, i_clear_err,
        output o_act, o_act_valid, o_busy, o_err
    );
endinterface

// File: rtl/sa_input_feeder.sv
// Systolic-array input feeder. Stores host-written activation vectors and,
// on each controller read, returns one NUM_ROWS-wide vector with the west-edge
// diagonal skew applied: lane 0 appears one cycle after the read, lane r r
// cycles later still. Reads stream one vector per cycle with no stalls.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sa_input_feeder_if.slave (write/read/clear inputs, act/valid/busy/err outputs)
module sa_input_feeder #(
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sa_input_feeder_if.slave bus
);
    localparam int unsigned VEC_W = NUM_ROWS * DATA_WIDTH;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    // Vector storage (data not reset) and per-entry valid bits.
    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;

    // Read stage: lane 0 output and the head of every skew chain.
    logic [VEC_W-1:0] rd_vec_q, rd_vec_d;
    logic             rd_vld_q, rd_vld_d;

    logic busy_q, busy_d;
    logic err_q,  err_d;

    logic             wr_in_range_c, rd_in_range_c;
    logic             wr_ok_c, wr_bad_c, rd_hit_c, rd_bad_c;
    logic [IDX_W-1:0] wr_idx_c, rd_idx_c;

    // Per-lane output taps and next-cycle "any valid" per skew chain.
    logic [VEC_W-1:0]    lane_act_c;
    logic [NUM_ROWS-1:0] lane_vld_c;
    logic [NUM_ROWS-1:0] skew_any_d;

    // Address qualification; out-of-range accesses never touch storage.
    always_comb begin
        wr_in_range_c = ({1'b0, bus.i_wr_addr} < DEPTH_EXT);
        rd_in_range_c = ({1'b0, bus.i_rd_addr} < DEPTH_EXT);
        wr_idx_c      = IDX_W'(bus.i_wr_addr);
        rd_idx_c      = IDX_W'(bus.i_rd_addr);
        wr_ok_c       = bus.i_wr_en && wr_in_range_c;
        wr_bad_c      = bus.i_wr_en && !wr_in_range_c;
        rd_hit_c      = bus.i_rd_en && rd_in_range_c && ent_vld_q[rd_idx_c];
        rd_bad_c      = bus.i_rd_en && !rd_hit_c;
    end

    // Storage write; the read stage samples mem_q before this edge updates it.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_idx_c] <= bus.i_wr_data;
        end
    end

    // Entry valid: clear drops everything, a same-cycle write still lands valid.
    always_comb begin
        ent_vld_d = bus.i_clear ? '0 : ent_vld_q;
        if (wr_ok_c) begin
            ent_vld_d[wr_idx_c] = 1'b1;
        end
    end

    // Read stage: a bad read still issues a valid (all-zero) vector so the
    // array's timing is preserved; no read issues a zero bubble.
    always_comb begin
        rd_vld_d = bus.i_rd_en;
        rd_vec_d = '0;
        if (rd_hit_c) begin
            rd_vec_d = mem_q[rd_idx_c];
        end
    end

    // Sticky error: a new error wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (bus.i_clear_err) begin
            err_d = 1'b0;
        end
        if (rd_bad_c || wr_bad_c) begin
            err_d = 1'b1;
        end
    end

    // Lane 0 has no skew registers.
    assign lane_act_c[0 +: DATA_WIDTH] = rd_vec_q[0 +: DATA_WIDTH];
    assign lane_vld_c[0]               = rd_vld_q;
    assign skew_any_d[0]               = 1'b0;

    // Lane r: r data+valid registers behind the read stage.
    for (genvar r = 1; r < NUM_ROWS; r++) begin : g_skew
        logic [DATA_WIDTH-1:0] dat_q [r];
        logic [DATA_WIDTH-1:0] dat_d [r];
        logic [r-1:0]          vld_q, vld_d;

        always_comb begin
            dat_d[0] = rd_vec_q[r*DATA_WIDTH +: DATA_WIDTH];
            vld_d[0] = rd_vld_q;
            for (int k = 1; k < r; k++) begin
                dat_d[k] = dat_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_q <= '{default: '0};
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign lane_act_c[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r-1];
        assign lane_vld_c[r]                          = vld_q[r-1];
        assign skew_any_d[r]                          = |vld_d;
    end

    // Busy mirrors next-cycle occupancy of the read stage and every skew stage.
    always_comb begin
        busy_d = rd_vld_d || (|skew_any_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q <= '0;
            rd_vec_q  <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ent_vld_q <= ent_vld_d;
            rd_vec_q  <= rd_vec_d;
            rd_vld_q  <= rd_vld_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_act       = lane_act_c;
    assign bus.o_act_valid = lane_vld_c;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_sa_input_feeder.sv
// Bench for sa_input_feeder: scripted and random traffic on a DEPTH=8 feeder
// checked by a queue scoreboard, plus directed range checks on a DEPTH=6 feeder.
module tb_sa_input_feeder;
    localparam int unsigned NR    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned VW    = NR * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sa_input_feeder_if #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    sa_input_feeder_if #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus6 ();

    sa_input_feeder #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    sa_input_feeder #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .DEPTH(6), .ADDR_WIDTH(AW)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // One entry per clock edge: the vector issued at that edge and the
    // busy/err state expected right after it.
    typedef struct packed {
        logic [VW-1:0] vec;
        logic          v;
        logic          err;
        logic          busy;
    } exp_t;

    exp_t exp_q [$];
    exp_t hist  [NR];

    // Reference model state.
    logic [VW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    bit            m_err;
    int            edge_n  = 0;
    int            last_rd = -100;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endfunction

    task automatic model_reset();
        foreach (m_vld[d]) m_vld[d] = 1'b0;
        m_err   = 1'b0;
        last_rd = -100;
        exp_q.delete();
        for (int r = 0; r < int'(NR); r++) hist[r] = '0;
    endtask

    // Drive one cycle of stimulus at a negedge and record what it should produce.
    task automatic drive(input bit we, input int wa, input logic [VW-1:0] wd, input bit clr,
                         input bit re, input int ra, input bit ce);
        exp_t e;
        bit   hit;
        bus.i_wr_en     = we;
        bus.i_wr_addr   = AW'(wa);
        bus.i_wr_data   = wd;
        bus.i_clear     = clr;
        bus.i_rd_en     = re;
        bus.i_rd_addr   = AW'(ra);
        bus.i_clear_err = ce;
        hit   = re && (ra < int'(DEPTH)) && m_vld[ra];
        e     = '0;
        e.v   = re;
        if (hit) e.vec = m_mem[ra];
        if (ce) m_err = 1'b0;
        if ((re && !hit) || (we && wa >= int'(DEPTH))) m_err = 1'b1;
        if (clr) foreach (m_vld[d]) m_vld[d] = 1'b0;
        if (we && wa < int'(DEPTH)) begin
            m_mem[wa] = wd;
            m_vld[wa] = 1'b1;
        end
        if (re) last_rd = edge_n;
        e.busy = (edge_n - last_rd) < int'(NR);
        e.err  = m_err;
        edge_n++;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: after every edge pop the newest issued vector; lane r shows the
    // vector issued r edges earlier.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_underflow @%0t: got empty queue expected an entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    for (int r = int'(NR) - 1; r > 0; r--) hist[r] = hist[r-1];
                    hist[0] = e;
                    for (int r = 0; r < int'(NR); r++) begin
                        chk($sformatf("lane%0d_valid", r), 64'(bus.o_act_valid[r]), 64'(hist[r].v));
                        chk($sformatf("lane%0d_data", r), 64'(bus.o_act[r*DW +: DW]),
                            64'(hist[r].vec[r*DW +: DW]));
                    end
                    chk("busy", 64'(bus.o_busy), 64'(e.busy));
                    chk("err", 64'(bus.o_err), 64'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.i_wr_en = 1'b0;  bus.i_wr_addr = '0;  bus.i_wr_data = '0;  bus.i_clear = 1'b0;
        bus.i_rd_en = 1'b0;  bus.i_rd_addr = '0;  bus.i_clear_err = 1'b0;
        bus6.i_wr_en = 1'b0; bus6.i_wr_addr = '0; bus6.i_wr_data = '0; bus6.i_clear = 1'b0;
        bus6.i_rd_en = 1'b0; bus6.i_rd_addr = '0; bus6.i_clear_err = 1'b0;
        model_reset();

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_act",   64'(bus.o_act),       64'h0);
        chk("rst_valid", 64'(bus.o_act_valid), 64'h0);
        chk("rst_busy",  64'(bus.o_busy),      64'h0);
        chk("rst_err",   64'(bus.o_err),       64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single read, skewed lanes.
        drive(1'b1, 0, 32'h4433_2211, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
        idle(5);

        // Fill all entries, stream them back with no gaps.
        for (int n = 0; n < int'(DEPTH); n++) drive(1'b1, n, {4{8'(n)}}, 1'b0, 1'b0, 0, 1'b0);
        for (int n = 0; n < int'(DEPTH); n++) drive(1'b0, 0, '0, 1'b0, 1'b1, n, 1'b0);
        idle(5);

        // Read-before-write on the same address.
        drive(1'b1, 2, 32'h5555_5555, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 2, 32'hAAAA_AAAA, 1'b0, 1'b1, 2, 1'b0);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 2, 1'b0);
        idle(5);

        // Clear then read an invalidated entry; then clear the error.
        drive(1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b0);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 3, 1'b0);
        idle(2);
        drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
        idle(4);

        // Clear with same-cycle write: written entry survives.
        drive(1'b1, 4, 32'hC0FF_EE04, 1'b1, 1'b0, 0, 1'b0);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 4, 1'b0);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 5, 1'b0);
        idle(5);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(4) < 2, int'($urandom_range(DEPTH - 1)), VW'($urandom),
                  $urandom_range(19) == 0, $urandom_range(4) < 3, int'($urandom_range(DEPTH - 1)),
                  $urandom_range(7) == 0);
        end
        idle(5);

        // Reset in the middle of a read.
        drive(1'b1, 7, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
        idle(1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_act",   64'(bus.o_act),       64'h0);
        chk("midrst_valid", 64'(bus.o_act_valid), 64'h0);
        chk("midrst_busy",  64'(bus.o_busy),      64'h0);
        chk("midrst_err",   64'(bus.o_err),       64'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(6);
        drive(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
        idle(5);
        mon_en = 1'b0;

        // DEPTH=6 instance: out-of-range read and write.
        bus6.i_rd_en = 1'b1; bus6.i_rd_addr = 3'd6;
        @(posedge clk); #1;
        bus6.i_rd_en = 1'b0;
        chk("d6_rd6_valid", 64'(bus6.o_act_valid), 64'h1);
        chk("d6_rd6_data",  64'(bus6.o_act),       64'h0);
        chk("d6_rd6_err",   64'(bus6.o_err),       64'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("d6_lane3_valid", 64'(bus6.o_act_valid), 64'h8);
        chk("d6_lane3_data",  64'(bus6.o_act),       64'h0);
        chk("d6_lane3_busy",  64'(bus6.o_busy),      64'h1);
        @(posedge clk); #1;
        chk("d6_busy_fall", 64'(bus6.o_busy), 64'h0);
        bus6.i_clear_err = 1'b1;
        @(posedge clk); #1;
        bus6.i_clear_err = 1'b0;
        chk("d6_clear_err", 64'(bus6.o_err), 64'h0);
        bus6.i_wr_en = 1'b1; bus6.i_wr_addr = 3'd7; bus6.i_wr_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus6.i_wr_en = 1'b0;
        chk("d6_wr7_err", 64'(bus6.o_err), 64'h1);
        bus6.i_clear_err = 1'b1;
        bus6.i_wr_en = 1'b1; bus6.i_wr_addr = 3'd5; bus6.i_wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        bus6.i_clear_err = 1'b0;
        bus6.i_wr_en = 1'b0;
        chk("d6_wr5_err", 64'(bus6.o_err), 64'h0);
        bus6.i_rd_en = 1'b1; bus6.i_rd_addr = 3'd5;
        @(posedge clk); #1;
        bus6.i_rd_en = 1'b0;
        chk("d6_rd5_data",  64'(bus6.o_act),       64'h78);
        chk("d6_rd5_valid", 64'(bus6.o_act_valid), 64'h1);
        chk("d6_rd5_err",   64'(bus6.o_err),       64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
